// File: rtl/sdb_operand_stage.sv
// sdb_operand_stage: registered operand-prep stage (a, b, p=a^b, pair propagate, carry-in) with a 2-entry skid buffer
module sdb_operand_stage #(
  parameter int width = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [0:width-1]   in_a,
  input  logic [0:width-1]   in_b,
  input  logic               in_c,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [0:width-1]   out_a,
  output logic [0:width-1]   out_b,
  output logic [0:width-1]   out_p,
  output logic [0:width/2-1] out_gp,
  output logic               out_c
);
  typedef struct packed {
    logic [0:width-1]   a;
    logic [0:width-1]   b;
    logic [0:width-1]   p;
    logic [0:width/2-1] gp;
    logic               c;
  } entry_t;
  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
  state_t state, next_state;
  entry_t main_q, skid_q, in_e;
  logic ready_q, in_fire, out_fire, load_main, load_skid;
  if (width % 2 != 0 || width <= 2) begin : g_bad_width
    $error("sdb_operand_stage: width must be even and > 2");
  end
  assign in_ready  = ready_q;
  assign out_valid = state != EMPTY;
  assign in_fire   = in_valid & ready_q;
  assign out_fire  = out_valid & out_ready;
  assign out_a     = main_q.a;
  assign out_b     = main_q.b;
  assign out_p     = main_q.p;
  assign out_gp    = main_q.gp;
  assign out_c     = main_q.c;
  // p and gp are computed here once so the adder sees pure register outputs
  always_comb begin
    in_e.a = in_a;
    in_e.b = in_b;
    in_e.p = in_a ^ in_b;
    in_e.c = in_c;
    in_e.gp = '0;
    for (int i = 0; i < width / 2; i++)
      in_e.gp[i] = (in_a[2*i] ^ in_b[2*i]) & (in_a[2*i+1] ^ in_b[2*i+1]);
  end
  always_comb begin
    next_state = state;
    load_main  = 1'b0;
    load_skid  = 1'b0;
    if (state == EMPTY) begin
      next_state = in_fire ? ONE : EMPTY;
      load_main  = in_fire;
    end else if (state == ONE) begin
      next_state = (in_fire & !out_fire) ? FULL : (!in_fire & out_fire) ? EMPTY : ONE;
      load_main  = in_fire & out_fire;
      load_skid  = in_fire & !out_fire;
    end else begin
      next_state = out_fire ? ONE : FULL;
      load_main  = out_fire;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= EMPTY;
      ready_q <= 1'b0;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      state   <= next_state;
      ready_q <= next_state != FULL;
      if (load_main) main_q <= (state == FULL) ? skid_q : in_e;
      if (load_skid) skid_q <= in_e;
    end
  end
endmodule

// File: tb/tb_sdb_operand_stage.sv
// tb_sdb_operand_stage: directed stimulus with a queue scoreboard and an independent output monitor
module tb_sdb_operand_stage;
  logic clk = 0, rst = 1;
  logic in_valid = 0, in_ready, in_c = 0;
  logic [0:7] in_a = '0, in_b = '0;
  logic out_valid, out_ready = 0, out_c;
  logic [0:7] out_a, out_b, out_p;
  logic [0:3] out_gp;
  int n_cmp = 0, n_bad = 0;
  logic [28:0] exp_q[$];

  sdb_operand_stage #(.width(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_c(in_c), .out_valid(out_valid),
    .out_ready(out_ready), .out_a(out_a), .out_b(out_b), .out_p(out_p),
    .out_gp(out_gp), .out_c(out_c)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] pair_prop(input logic [7:0] p);
    return {p[7] & p[6], p[5] & p[4], p[3] & p[2], p[1] & p[0]};
  endfunction

  // monitor: every accepted output must match the oldest expected entry
  initial forever begin
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("unexpected_output", {3'b0, out_a, out_b, out_p, out_gp, out_c}, 32'hDEAD);
      else chk("out_data", {3'b0, out_a, out_b, out_p, out_gp, out_c}, {3'b0, exp_q.pop_front()});
    end
  end

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] p, input logic [3:0] gp);
    logic fired = 0;
    int n = 0;
    in_valid = 1; in_a = a; in_b = b; in_c = c;
    while (!fired && n < 50) begin
      @(negedge clk);
      fired = in_ready;
      if (fired) exp_q.push_back({a, b, p, gp, c});
      @(posedge clk); #1;
      n++;
    end
    if (!fired) chk("send_timeout", 0, 1);
    in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk); #1;
    chk("drain_out_valid", out_valid, 0);
  endtask

  initial begin
    // reset
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_data", {3'b0, out_a, out_b, out_p, out_gp, out_c}, 0);
    end
    rst = 0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", in_ready, 1);
    chk("post_rst_out_valid", out_valid, 0);

    // single op
    out_ready = 1;
    send(8'hA5, 8'h3C, 1, 8'h99, 4'h0);
    chk("single_valid", out_valid, 1);
    chk("single_p", out_p, 8'h99);
    chk("single_gp", out_gp, 4'h0);
    chk("single_c", out_c, 1);
    @(posedge clk); #1;
    chk("single_valid_after", out_valid, 0);

    // back-pressure
    out_ready = 0;
    send(8'h01, 8'h01, 0, 8'h00, 4'h0);
    send(8'hFF, 8'h00, 1, 8'hFF, 4'hF);
    chk("bp_in_ready_full", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_hold_p", out_p, 8'h00);
    fork
      send(8'h0F, 8'hF0, 0, 8'hFF, 4'hF);
      begin
        for (int i = 0; i < 3; i++) begin
          @(posedge clk); #1;
          chk("bp_hold_a", out_a, 8'h01);
          chk("bp_stall_ready", in_ready, 0);
        end
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk("bp_no_gap", out_valid, 1);
        end
      end
    join
    drain();

    // streaming, exercising in_fire & out_fire together in ONE
    out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      logic [7:0] a;
      a = 8'(i * 17);
      send(a, 8'h0F, i[0], a ^ 8'h0F, pair_prop(a ^ 8'h0F));
      chk("stream_out_valid", out_valid, 1);
      chk("stream_main_replaced", out_a, a);
      chk("stream_in_ready", in_ready, 1);
    end
    drain();

    // reset while FULL
    out_ready = 0;
    send(8'h12, 8'h34, 1, 8'h26, 4'h0);
    send(8'h56, 8'h78, 0, 8'h2E, 4'h2);
    chk("full_in_ready", in_ready, 0);
    rst = 1;
    exp_q.delete();
    @(posedge clk); #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 0);
    chk("midrst_data", {3'b0, out_a, out_b, out_p, out_gp, out_c}, 0);
    rst = 0;
    @(posedge clk); #1;
    chk("midrst_release_ready", in_ready, 1);
    out_ready = 1;
    send(8'hC3, 8'h3C, 1, 8'hFF, 4'hF);
    chk("midrst_new_valid", out_valid, 1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
